// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480 VGA timing generator that streams a frame buffer
// out of a fixed-latency memory. Sync and frame markers are delayed by the
// same amount as the read data, so all pins leave the block cycle-aligned.
//
// Read contract: RD_EN=1 with RD_ADDR is a read request that is always
// accepted (no back-pressure); RD_DATA for that request is sampled exactly
// MEM_LATENCY clocks later. MEM_LATENCY must lie in 1..4.
module vga_frame_reader #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic                  RD_EN,
  output logic [ADDR_WIDTH-1:0] RD_ADDR,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  output logic [DATA_WIDTH-1:0] PIXEL_OUT,
  output logic                  HSYNC,
  output logic                  VSYNC,
  output logic                  FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

  // Per-position markers that travel alongside the memory read.
  typedef struct packed {
    logic act;
    logic hs_n;
    logic vs_n;
    logic first;
  } tag_t;

  localparam tag_t TAG_IDLE = '{act: 1'b0, hs_n: 1'b1, vs_n: 1'b1, first: 1'b0};

  logic [HW-1:0]         h_cnt_q, h_cnt_d;
  logic [VW-1:0]         v_cnt_q, v_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  tag_t                  tag_now;
  tag_t [MEM_LATENCY-1:0] pipe_q, pipe_d;
  tag_t [MEM_LATENCY:0]   pipe_chain;
  tag_t                  tag_tail;
  logic [DATA_WIDTH-1:0] pix_q;
  logic                  hsync_q, vsync_q, fs_q;
  logic                  frame_wrap;

  // Raster position: h wraps every line, v advances on each h wrap.
  always_comb begin
    h_cnt_d    = h_cnt_q + 1'b1;
    v_cnt_d    = v_cnt_q;
    frame_wrap = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      if (v_cnt_q == V_LAST) begin
        v_cnt_d = '0;
      end else begin
        v_cnt_d = v_cnt_q + 1'b1;
      end
    end
  end

  // Decode of the current position into read strobe and pre-delay markers.
  always_comb begin
    tag_now       = TAG_IDLE;
    tag_now.act   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    tag_now.hs_n  = !((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
    tag_now.vs_n  = !((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    tag_now.first = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Linear read address: advances per read, restarts with every frame and
  // never runs past the last pixel of the frame.
  always_comb begin
    addr_d = addr_q;
    if (frame_wrap) begin
      addr_d = '0;
    end else if (tag_now.act) begin
      if (addr_q == ADDR_LAST) begin
        addr_d = '0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  // Marker delay line, MEM_LATENCY stages deep to match the memory.
  always_comb begin
    pipe_chain = {pipe_q, tag_now};
    pipe_d     = pipe_chain[MEM_LATENCY-1:0];
    tag_tail   = pipe_q[MEM_LATENCY-1];
  end

  // State registers: counters, address, delay line and output stage.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      addr_q  <= '0;
      pipe_q  <= {MEM_LATENCY{TAG_IDLE}};
      pix_q   <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      addr_q  <= addr_d;
      pipe_q  <= pipe_d;
      pix_q   <= tag_tail.act ? RD_DATA : '0;
      hsync_q <= tag_tail.hs_n;
      vsync_q <= tag_tail.vs_n;
      fs_q    <= tag_tail.first;
    end
  end

  assign RD_EN       = tag_now.act;
  assign RD_ADDR     = addr_q;
  assign PIXEL_OUT   = pix_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a reduced raster (15x8 clocks, 8x4 visible)
// so whole frames fit in a short run. A latency-2 memory returns RD_ADDR[0]
// for reads and 1 when no read was issued, so blanking must be masked.
module tb_vga_frame_reader;

  localparam int AW  = 19;
  localparam int DW  = 1;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] pixel;
  logic          hsync;
  logic          vsync;
  logic          fs;

  vga_frame_reader #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .MEM_LATENCY(LAT), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .RD_EN(rd_en),
    .RD_ADDR(rd_addr),
    .RD_DATA(rd_data),
    .PIXEL_OUT(pixel),
    .HSYNC(hsync),
    .VSYNC(vsync),
    .FRAME_START(fs)
  );

  // Clock and memory model
  always #5 clk = ~clk;

  logic [LAT-1:0] mem_pipe = '0;
  always @(posedge clk) mem_pipe <= {mem_pipe[LAT-2:0], (rd_en ? rd_addr[0] : 1'b1)};
  assign rd_data = mem_pipe[LAT-1];

  // Scoreboard state
  logic [AW:0] rd_q[$];   // {rd_en, rd_addr} expected this cycle
  logic [3:0]  exp_q[$];  // {pixel, hsync, vsync, frame_start}
  localparam logic [3:0] RESET_OUT = 4'b0110;

  int total = 0;
  int bad   = 0;
  int mon_mode = 0;       // 0 idle, 1 reset-value checks, 2 scoreboard
  int k = 0;

  // Position k clocks after (re)start: 15 clocks/line, 8 lines/frame.
  function automatic logic [AW:0] model_rd(input int kk);
    int h, v;
    logic act;
    h   = kk % 15;
    v   = (kk / 15) % 8;
    act = (h < 8) && (v < 4);
    return {act, AW'(v * 8 + h)};
  endfunction

  // Hsync low on h 10..12, vsync low on lines 5..6, pixel = address parity.
  function automatic logic [3:0] model_out(input int kk);
    int h, v;
    logic act, pix, hs, vs, first;
    h     = kk % 15;
    v     = (kk / 15) % 8;
    act   = (h < 8) && (v < 4);
    pix   = act && (h % 2 == 1);
    hs    = !((h >= 10) && (h <= 12));
    vs    = !((v >= 5) && (v <= 6));
    first = (h == 0) && (v == 0);
    return {pix, hs, vs, first};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Driver: issue one clock of raster and queue its expectations.
  task automatic step();
    rd_q.push_back(model_rd(k));
    exp_q.push_back(model_out(k));
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic seed_reset_outputs();
    exp_q.delete();
    rd_q.delete();
    repeat (LAT + 1) exp_q.push_back(RESET_OUT);
  endtask

  // Monitor: compare every clock on the falling edge, collect frame stats.
  int out_k = 0;
  int rd_cnt = 0, hs_low = 0, vs_low = 0;
  int hs_fall = -1, hs_fall2 = -1, vs_fall = -1;
  int fs_ks[$];
  logic prev_hs = 1'b1, prev_vs = 1'b1;
  logic [AW:0] e_rd;
  logic [3:0]  e_out;

  always @(negedge clk) begin
    if (mon_mode == 1) begin
      chk("rst_pixel", int'(pixel), 0);
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_frame_start", int'(fs), 0);
    end else if (mon_mode == 2) begin
      if (rd_q.size() == 0) begin
        chk("rd_queue_underflow", 0, 1);
      end else begin
        e_rd = rd_q.pop_front();
        chk("rd_en", int'(rd_en), int'(e_rd[AW]));
        if (e_rd[AW]) chk("rd_addr", int'(rd_addr), int'(e_rd[AW-1:0]));
      end
      chk("rd_addr_max", int'(rd_addr <= 19'd31), 1);
      if (exp_q.size() == 0) begin
        chk("out_queue_underflow", 0, 1);
      end else begin
        e_out = exp_q.pop_front();
        chk("pixel", int'(pixel), int'(e_out[3]));
        chk("hsync", int'(hsync), int'(e_out[2]));
        chk("vsync", int'(vsync), int'(e_out[1]));
        chk("frame_start", int'(fs), int'(e_out[0]));
      end
      if (out_k < 120 && rd_en) rd_cnt++;
      if (out_k >= 3 && out_k < 123) begin
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
      end
      if (prev_hs && !hsync) begin
        if (hs_fall < 0) hs_fall = out_k;
        else if (hs_fall2 < 0) hs_fall2 = out_k;
      end
      if (prev_vs && !vsync && vs_fall < 0) vs_fall = out_k;
      if (fs) fs_ks.push_back(out_k);
      prev_hs = hsync;
      prev_vs = vsync;
      if (out_k == 248) begin
        chk("frame_start_first", (fs_ks.size() > 0) ? fs_ks[0] : -1, 3);
        chk("frame_start_second", (fs_ks.size() > 1) ? fs_ks[1] : -1, 123);
        chk("rd_en_per_frame", rd_cnt, 32);
        chk("hsync_low_per_frame", hs_low, 24);
        chk("hsync_first_fall", hs_fall, 13);
        chk("hsync_line_period", hs_fall2 - hs_fall, 15);
        chk("vsync_low_clocks", vs_low, 30);
        chk("vsync_first_fall", vs_fall, 78);
      end
      out_k++;
    end
  end

  // Main sequence: reset, two-plus frames, mid-frame reset, recovery.
  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_mode = 1;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    seed_reset_outputs();
    k = 0;
    mon_mode = 2;
    repeat (275) step();

    // k=275 sits at h=5, v=2 of the third frame: pulse reset for one clock.
    rst = 1'b1;
    rd_q.push_back(model_rd(k));
    @(posedge clk);
    #1;
    rst = 1'b0;
    seed_reset_outputs();
    k = 0;
    repeat (130) step();
    mon_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
